// File: rtl/pix_packer.sv
// pix_packer: packs 12-bit pixels into 16-bit words (4 pixels -> 3 words)
// with frame delimiting, final-word tagging and per-frame word counting.
module pix_packer #(
  parameter int WordCountWidth = 22
) (
  input  logic                      pix_clk,
  input  logic                      pix_rst,
  input  logic                      pix_frameValid,
  input  logic [11:0]               in_d,
  input  logic                      in_valid,
  output logic                      in_pop,
  output logic [15:0]               out_d,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [WordCountWidth-1:0] frameWordCount,
  output logic                      frameDone,
  output logic                      overflow
);

  typedef enum logic [2:0] {
    IDLE, RUN, DRAIN, FLUSH, WAIT_LAST
  } state_e;

  localparam logic [WordCountWidth-1:0] CntOne =
    WordCountWidth'(1);

  state_e state_q, state_d;
  logic [27:0] acc_q, acc_d;
  logic [4:0]  bits_q, bits_d;
  logic [15:0] stg_q, stg_d;
  logic        stg_v_q, stg_v_d;
  logic        stg_l_q, stg_l_d;
  logic [15:0] od_q, od_d;
  logic        ov_q, ov_d;
  logic        ol_q, ol_d;
  logic [WordCountWidth-1:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        fv_q;
  logic        pend_q, pend_d;

  logic       rise, hold, packing;
  logic       out_load, xfer;
  logic       emit, fl_emit, adv;
  logic       pop, done;
  logic [4:0] rem;

  always_comb begin
    rise     = pix_frameValid && !fv_q;
    hold     = pend_q || rise;
    packing  = (state_q == RUN) || (state_q == DRAIN);
    out_load = !ov_q || out_ready;
    xfer     = ov_q && out_ready;
    emit     = packing && (bits_q >= 5'd16)
               && (!stg_v_q || out_load);
    fl_emit  = (state_q == FLUSH) && (bits_q != 5'd0)
               && (!stg_v_q || out_load);
    rem      = emit ? bits_q - 5'd16 : bits_q;
    // Stage word is held back until a successor exists or the frame ends.
    adv      = stg_v_q && out_load
               && (emit || fl_emit || state_q == WAIT_LAST);
    pop      = 1'b0;
    if (state_q == IDLE) begin
      pop = in_valid && !hold;
    end else if (packing) begin
      pop = in_valid && !hold && (rem <= 5'd16);
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = emit ? {16'd0, acc_q[27:16]} : acc_q;
    bits_d  = rem;
    stg_d   = stg_q;
    stg_v_d = stg_v_q;
    stg_l_d = stg_l_q;
    od_d    = od_q;
    ov_d    = ov_q;
    ol_d    = ol_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    pend_d  = pend_q || (rise && state_q != IDLE);
    done    = 1'b0;
    if (packing && pop) begin
      acc_d  = acc_d | ({16'd0, in_d} << rem);
      bits_d = rem + 5'd12;
    end
    if (out_load) begin
      ov_d = adv;
      ol_d = adv && stg_l_q;
      if (adv) od_d = stg_q;
    end
    if (emit || fl_emit) begin
      stg_d   = acc_q[15:0];
      stg_v_d = 1'b1;
      stg_l_d = fl_emit;
    end else if (adv) begin
      stg_v_d = 1'b0;
      stg_l_d = 1'b0;
    end
    if (xfer) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + CntOne;
    end
    unique case (state_q)
      IDLE: begin
        if (hold) begin
          state_d = RUN;
          pend_d  = 1'b0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        if (!pix_frameValid) state_d = DRAIN;
      end
      DRAIN: begin
        if ((!in_valid || hold) && bits_q < 5'd16)
          state_d = FLUSH;
      end
      FLUSH: begin
        if (bits_q != 5'd0) begin
          if (fl_emit) begin
            acc_d   = '0;
            bits_d  = '0;
            state_d = WAIT_LAST;
          end
        end else if (stg_v_q) begin
          stg_l_d = 1'b1;
          state_d = WAIT_LAST;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_LAST: begin
        if (xfer && ol_q) begin
          done    = 1'b1;
          state_d = IDLE;
          stg_v_d = 1'b0;
          stg_l_d = 1'b0;
          ov_d    = 1'b0;
          ol_d    = 1'b0;
          acc_d   = '0;
          bits_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      bits_q  <= '0;
      stg_q   <= '0;
      stg_v_q <= 1'b0;
      stg_l_q <= 1'b0;
      od_q    <= '0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      fv_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      bits_q  <= bits_d;
      stg_q   <= stg_d;
      stg_v_q <= stg_v_d;
      stg_l_q <= stg_l_d;
      od_q    <= od_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      fv_q    <= pix_frameValid;
      pend_q  <= pend_d;
    end
  end

  assign in_pop         = pop && !pix_rst;
  assign frameDone      = done && !pix_rst;
  assign out_d          = od_q;
  assign out_valid      = ov_q;
  assign out_last       = ol_q;
  assign frameWordCount = cnt_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_pix_packer.sv
// tb_pix_packer: directed frames checked against a bit-stream packing
// model, plus literal word expectations.
module tb_pix_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fv;
  logic [11:0] in_d;
  logic        in_valid;
  logic        in_pop;
  logic [15:0] out_d;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [21:0] fwc;
  logic        frameDone;
  logic        overflow;

  pix_packer #(.WordCountWidth(22)) dut (
    .pix_clk        (clk),
    .pix_rst        (rst),
    .pix_frameValid (fv),
    .in_d           (in_d),
    .in_valid       (in_valid),
    .in_pop         (in_pop),
    .out_d          (out_d),
    .out_valid      (out_valid),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .frameWordCount (fwc),
    .frameDone      (frameDone),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] feed[$];
  logic [11:0] frame_px[$];
  logic [16:0] exp_q[$];
  logic [16:0] got[$];

  int rdy_mode    = 0;
  int done_cnt    = 0;
  int n_pops      = 0;
  int cyc_n       = 0;
  int first_pop   = -1;
  int last_pop    = -1;
  int first_out   = -1;
  int stall_pop   = 0;
  bit allow_empty = 1'b0;
  bit in_frame    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: frame pixels laid end to end as a little-endian bit stream,
  // cut into 16-bit words, final word zero-padded and tagged last.
  function automatic int model_push();
    logic [6143:0] bits;
    int nw;
    bits = '0;
    for (int i = 0; i < frame_px.size(); i++)
      bits[12*i +: 12] = frame_px[i];
    nw = (12 * frame_px.size() + 15) / 16;
    for (int k = 0; k < nw; k++)
      exp_q.push_back({k == nw - 1, bits[16*k +: 16]});
    for (int i = 0; i < frame_px.size(); i++)
      feed.push_back(frame_px[i]);
    return nw;
  endfunction

  logic        prev_stall = 1'b0;
  logic [16:0] prev_o = '0;

  always @(negedge clk) begin
    logic [16:0] e;
    logic        xfer;
    logic        exp_done;
    cyc_n++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", 32'({out_valid, out_last, out_d}),
            32'({1'b1, prev_o}));
      prev_stall = out_valid && !out_ready;
      prev_o     = {out_last, out_d};
      if (in_valid && in_pop) begin
        n_pops++;
        if (first_pop < 0) first_pop = cyc_n;
        last_pop = cyc_n;
      end
      if (in_frame && in_valid && !in_pop) stall_pop++;
      if (out_valid && first_out < 0) first_out = cyc_n;
      xfer     = out_valid && out_ready;
      exp_done = 1'b0;
      if (xfer) begin
        got.push_back({out_last, out_d});
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none",
                   {out_last, out_d});
        end else begin
          e = exp_q.pop_front();
          chk("word", 32'({out_last, out_d}), 32'(e));
          exp_done = e[16];
        end
      end
      if (frameDone) done_cnt++;
      if (!allow_empty)
        chk("frameDone", 32'(frameDone), 32'(exp_done));
    end
  end

  task automatic tick();
    bit p;
    @(negedge clk);
    p = in_valid && in_pop;
    @(posedge clk);
    #1;
    if (p && feed.size() > 0) feed.delete(0);
    in_valid = feed.size() > 0;
    in_d     = (feed.size() > 0) ? feed[0] : 12'h000;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic wait_done(input string nm, input int d0);
    int b;
    b = 0;
    while (done_cnt == d0 && b < 5000) begin
      tick();
      b++;
    end
    chk({nm, "_done"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic run_frame(input string nm, input int mode,
                           output int nw);
    int b;
    int d0;
    nw = model_push();
    got.delete();
    first_pop = -1;
    first_out = -1;
    stall_pop = 0;
    rdy_mode  = mode;
    fv        = 1'b1;
    in_frame  = 1'b1;
    b = 0;
    while (feed.size() > 0 && b < 5000) begin
      tick();
      b++;
    end
    fv       = 1'b0;
    in_frame = 1'b0;
    d0 = done_cnt;
    wait_done(nm, d0);
    tick();
    tick();
    chk({nm, "_done_pulse"}, 32'(done_cnt - d0), 32'd1);
    chk({nm, "_count"}, 32'(fwc), 32'(nw));
    chk({nm, "_nwords"}, 32'(got.size()), 32'(nw));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [16:0] lit_full[6];
    logic [16:0] lit_part[4];
    logic [16:0] lit_b2b[5];
    int nw;
    int nA;
    int nB;
    int d0;
    int p0;
    int b;

    lit_full = '{17'h02001, 17'h00300, 17'h00040,
                 17'h06005, 17'h00700, 17'h10080};
    lit_part = '{17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h10FFF};
    lit_b2b  = '{17'h03ABC, 17'h10012,
                 17'h02111, 17'h03322, 17'h14443};

    rst       = 1'b1;
    fv        = 1'b1;
    in_valid  = 1'b1;
    in_d      = 12'hABC;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_pop", 32'(in_pop), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_out_d", 32'(out_d), 32'd0);
      chk("rst_count", 32'(fwc), 32'd0);
      chk("rst_done", 32'(frameDone), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    fv       = 1'b0;
    in_valid = 1'b0;
    in_d     = '0;
    repeat (3) tick();

    frame_px.delete();
    for (int i = 1; i <= 8; i++) frame_px.push_back(12'(i));
    run_frame("full", 0, nw);
    for (int i = 0; i < 6; i++)
      if (i < got.size())
        chk("full_lit", 32'(got[i]), 32'(lit_full[i]));
    chk("full_latency", 32'(first_out - first_pop), 32'd4);
    chk("full_rate", 32'(last_pop - first_pop), 32'd7);
    chk("full_overflow", 32'(overflow), 32'd0);

    frame_px.delete();
    repeat (5) frame_px.push_back(12'hFFF);
    run_frame("part", 0, nw);
    for (int i = 0; i < 4; i++)
      if (i < got.size())
        chk("part_lit", 32'(got[i]), 32'(lit_part[i]));

    got.delete();
    allow_empty = 1'b1;
    rdy_mode    = 0;
    fv          = 1'b1;
    repeat (10) tick();
    fv = 1'b0;
    d0 = done_cnt;
    wait_done("empty", d0);
    tick();
    tick();
    allow_empty = 1'b0;
    chk("empty_done_pulse", 32'(done_cnt - d0), 32'd1);
    chk("empty_count", 32'(fwc), 32'd0);
    chk("empty_nwords", 32'(got.size()), 32'd0);

    frame_px.delete();
    for (int i = 0; i < 400; i++)
      frame_px.push_back(12'($urandom));
    run_frame("bp", 2, nw);
    chk("bp_words", 32'(nw), 32'd300);
    chk("bp_in_pop_drop", 32'(stall_pop > 0), 32'd1);

    got.delete();
    frame_px.delete();
    frame_px.push_back(12'hABC);
    frame_px.push_back(12'h123);
    nA       = model_push();
    rdy_mode = 1;
    fv       = 1'b1;
    b = 0;
    while (feed.size() > 0 && b < 100) begin
      tick();
      b++;
    end
    fv = 1'b0;
    repeat (6) tick();
    chk("b2b_stalled_valid", 32'(out_valid), 32'd1);
    frame_px.delete();
    frame_px.push_back(12'h111);
    frame_px.push_back(12'h222);
    frame_px.push_back(12'h333);
    frame_px.push_back(12'h444);
    nB = model_push();
    fv = 1'b1;
    d0 = done_cnt;
    p0 = n_pops;
    repeat (6) tick();
    chk("b2b_no_pop", 32'(n_pops - p0), 32'd0);
    chk("b2b_in_valid", 32'(in_valid), 32'd1);
    rdy_mode = 0;
    wait_done("b2b_A", d0);
    chk("b2b_countA", 32'(fwc), 32'(nA));
    tick();
    chk("b2b_count_clear", 32'(fwc), 32'd0);
    b = 0;
    while (feed.size() > 0 && b < 100) begin
      tick();
      b++;
    end
    fv = 1'b0;
    d0 = done_cnt;
    wait_done("b2b_B", d0);
    tick();
    chk("b2b_countB", 32'(fwc), 32'(nB));
    chk("b2b_nwords", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < got.size())
        chk("b2b_lit", 32'(got[i]), 32'(lit_b2b[i]));

    repeat (3) tick();
    chk("exp_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pix_packer.md
# pix_packer

Downstream stage of the pixel FIFO. Pops 12-bit sensor pixels from the FIFO in the `pix_clk` domain and packs every 4 pixels into three 16-bit words for the SDRAM write path. Delimits frames from `pix_frameValid`: zero-pads and tags the final word of each frame, and reports per-frame word counts. Sustains 1 pixel/cycle when `out_ready` is held high.

## Interface
- `WordCountWidth`, default 22. Width of `frameWordCount`.
- `pix_clk` in 1. Pixel clock; all logic on its rising edge.
- `pix_rst` in 1. Reset, synchronous, active-high.
- `pix_frameValid` in 1. Sensor frame-valid level.
- `in_d` in 12. Pixel at the FIFO head.
- `in_valid` in 1. FIFO head holds valid data.
- `in_pop` out 1. Pixel consumed this cycle. Combinational from current state.
- `out_d` out 16. Packed word.
- `out_valid` out 1. `out_d` is valid.
- `out_last` out 1. `out_d` is the final word of the frame.
- `out_ready` in 1. Consumer accepts the word this cycle.
- `frameWordCount` out WordCountWidth. Number of words transferred in the current/most recent frame.
- `frameDone` out 1. One-cycle pulse at frame completion.
- `overflow` out 1. Sticky; set when `frameWordCount` saturates.

## Operation
- Packing order is little-endian over the 48-bit group {p3,p2,p1,p0}:
  - w0 = {p1[3:0], p0}
  - w1 = {p2[7:0], p1[11:4]}
  - w2 = {p3, p2[11:8]}
- Accumulator: 28-bit bit-buffer plus `accBits` (0..28).
- Pipeline: accumulator → stage register → output register.
  - `emit` = `accBits`≥16 and the stage can load. The stage can load if it is empty or advancing this cycle.
  - The stage advances into the output register only when a newer word is emitted or the frame is flushing. This hold-back lets `out_last` tag the true final word.
  - Output register: loads when empty or when `out_valid`&&`out_ready`.
- `in_pop` = `in_valid` && state∈{RUN,DRAIN} && (`accBits` − 16·`emit`) ≤ 16.
- `accBits_next` = `accBits` − 16·`emit` + 12·`in_pop`.
- Frame edges come from registered `pix_frameValid` (`fvPrev`, reset value 0).
- States:
  - IDLE: `in_pop`=`in_valid`, and popped data is discarded. On a rising edge: clear `frameWordCount` and `overflow`, go to RUN.
  - RUN: pack. On a falling edge, go to DRAIN.
  - DRAIN: keep popping while `in_valid`. When `in_valid`=0 and `accBits`<16, go to FLUSH.
  - FLUSH: if `accBits`>0, emit {zero pad, acc} as a word; `accBits`←0. Then tag the stage word as last and go to WAIT_LAST. If the stage is empty (frame produced no words), pulse `frameDone` and go to IDLE.
  - WAIT_LAST: on a transfer with `out_last`=1, pulse `frameDone` that cycle, clear the pipeline, and go to IDLE.
- A rising `pix_frameValid` during DRAIN/FLUSH/WAIT_LAST is latched as pending.
  - No new pixels are popped until the current frame completes; the FIFO absorbs or drops them.
  - The pending frame enters RUN the cycle after IDLE is reached.
- `frameWordCount` increments on each transfer and saturates at all-ones. Saturation sets `overflow`, which holds until the next frame start.

## Timing
- Reset values: `in_pop` 0 while `pix_rst`, `out_valid` 0, `out_last` 0, `out_d` 0, `frameWordCount` 0, `frameDone` 0, `overflow` 0. State is IDLE and `accBits` is 0.
- Reset mid-frame drops all buffered data with no `frameDone`. If `pix_frameValid` is high at reset release, RUN starts 1 cycle later.
- Latency at full rate: p0 popped in cycle 0 → w0 on `out_d` with `out_valid` in cycle 4.
- Steady state: 4 pops and 3 transfers per 4 cycles.
- `out_d`/`out_valid`/`out_last` hold stable while `out_valid`&&!`out_ready`.
- No pixel is lost or duplicated under any `out_ready` pattern.
- `frameDone` is a single-cycle pulse. It coincides with the last transfer, or occurs one cycle after FLUSH for an empty frame.

## Test plan
- Reset: hold `pix_rst` 3 cycles with `in_valid`=1 and `pix_frameValid`=1 → `in_pop`=0, `out_valid`=0, all outputs 0.
- Full frame: 8 pixels 0x001..0x008 at 1/cycle, `out_ready`=1 → words 0x2001, 0x0300, 0x0040, 0x6005, 0x0700, 0x0080. `out_last` only on 0x0080, `frameWordCount`=6, one `frameDone` pulse.
- Partial group: 5 pixels of 0xFFF → 0xFFFF, 0xFFFF, 0xFFFF, then 0x0FFF with `out_last`; `frameWordCount`=4.
- Backpressure: random `out_ready` (~50%) over 400 pixels → 300 words matching the reference model, `out_d` stable while stalled, `in_pop` drops while the pipeline is full.
- Empty frame: `pix_frameValid` high 10 cycles with `in_valid`=0 → no `out_valid`, `frameDone` pulse, `frameWordCount`=0.
- Back-to-back frames: new rising edge while in WAIT_LAST with `out_ready`=0 → `in_pop`=0 until the last word transfers, then the count clears and the second frame packs correctly.
